// File: rtl/mips_pkg.sv
// mips_pkg: encodings and widths shared by the decoder, MEM and WB stages.
package mips_pkg;
  localparam int REG_AW = 5;
  typedef enum logic [1:0] {WB_ALU = 2'b00, WB_LOAD = 2'b01, WB_LINK = 2'b10} wb_sel_e;
  typedef enum logic [2:0] {LD_W = 3'd0, LD_H = 3'd1, LD_HU = 3'd2, LD_B = 3'd3, LD_BU = 3'd4} ld_type_e;
endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM/WB pipeline bus; the MEM stage drives it, the WB stage consumes it.
interface wb_stage_if #(parameter int DATA_W = 32, parameter int REG_AW = mips_pkg::REG_AW);
  logic              valid;
  logic              regWr;
  logic [REG_AW-1:0] WriteReg;
  logic [1:0]        wbSel;
  logic [2:0]        ldType;
  logic [1:0]        addrLo;
  logic [DATA_W-1:0] aluOut;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] pc8;
  modport master (output valid, regWr, WriteReg, wbSel, ldType, addrLo, aluOut, rdata, pc8);
  modport slave  (input  valid, regWr, WriteReg, wbSel, ldType, addrLo, aluOut, rdata, pc8);
endinterface

// File: rtl/load_align.sv
// load_align: picks and extends the addressed byte/half of a little-endian load word.
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  ld_type,
  output logic [31:0] data,
  output logic        misalign
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  assign byte_v = rdata[8*addr_lo +: 8];
  assign half_v = rdata[16*addr_lo[1] +: 16];
  assign data = ld_type == LD_B  ? {{24{byte_v[7]}}, byte_v} :
                ld_type == LD_BU ? {24'b0, byte_v} :
                ld_type == LD_H  ? {{16{half_v[15]}}, half_v} :
                ld_type == LD_HU ? {16'b0, half_v} : rdata;
  // Unknown load types behave as LW, including the word-alignment check.
  assign misalign = (ld_type == LD_H || ld_type == LD_HU) ? addr_lo[0] :
                    (ld_type == LD_B || ld_type == LD_BU) ? 1'b0 : |addr_lo;
endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB register, write-back mux, GPR write qualification and retire counter.
module wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = mips_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  wb_stage_if.slave         mem,
  output logic              regWr,
  output logic [REG_AW-1:0] WriteReg,
  output logic [DATA_W-1:0] busW,
  output logic              wb_valid,
  output logic              misalign_err,
  output logic [31:0]       retire_cnt
);
  logic              valid_q, regwr_q;
  logic [REG_AW-1:0] wr_q;
  logic [1:0]        sel_q, lo_q;
  logic [2:0]        ld_q;
  logic [DATA_W-1:0] alu_q, rdata_q, pc8_q, ld_data;
  logic [31:0]       cnt_q;
  logic              ld_mis, mis;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      regwr_q <= 1'b0;
      wr_q    <= '0;
      sel_q   <= '0;
      ld_q    <= '0;
      lo_q    <= '0;
      alu_q   <= '0;
      rdata_q <= '0;
      pc8_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= mem.valid & ~stall & ~flush;
      regwr_q <= mem.regWr;
      wr_q    <= mem.WriteReg;
      sel_q   <= mem.wbSel;
      ld_q    <= mem.ldType;
      lo_q    <= mem.addrLo;
      alu_q   <= mem.aluOut;
      rdata_q <= mem.rdata;
      pc8_q   <= mem.pc8;
      cnt_q   <= cnt_q + {31'b0, valid_q & ~misalign_err};
    end
  end
  load_align u_align (
    .rdata    (rdata_q),
    .addr_lo  (lo_q),
    .ld_type  (ld_q),
    .data     (ld_data),
    .misalign (ld_mis)
  );
  assign mis          = (sel_q == WB_LOAD) & ld_mis;
  assign busW         = !valid_q ? '0 : sel_q == WB_LINK ? pc8_q : sel_q == WB_LOAD ? ld_data : alu_q;
  assign WriteReg     = wr_q;
  assign regWr        = valid_q & regwr_q & ~mis & (|wr_q);
  assign misalign_err = valid_q & regwr_q & mis;
  assign wb_valid     = valid_q;
  assign retire_cnt   = cnt_q;
endmodule
